// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
//   REG_AW / DATA_W / BE_W : register address, data and byte-enable widths
//   FULL_BE                : byte enables for a full-word write (MDU results)
//   wr_req_t               : one register-file write {addr, data, be}
//   arb_state_t            : arbitration FSM state {NORMAL, FORCE}
package wb_arb_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [BE_W-1:0] FULL_BE = 4'hF;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } wr_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wr_fifo2.sv
// Two-entry FIFO of register-file write requests.
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push       : write push_data at the tail (ignored when full unless pop)
//   push_data  : request to enqueue
//   pop        : drop the head entry (ignored when empty)
//   head       : oldest entry, meaningful only when empty=0
//   full/empty : occupancy flags
// Push and pop together on a full FIFO is legal: the head leaves, the new
// entry lands behind the remaining one and the count stays at 2.
module wr_fifo2
  import wb_arb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wr_req_t push_data,
  input  logic    pop,
  output wr_req_t head,
  output logic    full,
  output logic    empty
);

  wr_req_t    mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register file's single write port between the writeback stage
// (WB) and the multiply/divide unit (MDU).
//   clk, rst                      : clock, asynchronous active-high reset
//   wb_valid/addr/data/be         : WB write request
//   wb_stall                      : WB must hold its request (Moore, FORCE)
//   mdu_valid/ready, addr/data    : MDU result handshake (full-word writes)
//   issue_valid, issue_addr       : MDU op issued, marks destination pending
//   rs/rt/rd_addr -> rs/rt/rd_busy: combinational pending lookups
//   rf_wr_en/addr/data/be         : registered write port to the register file
//   state_dbg                     : current arbitration state (1 = FORCE)
// Handshake: an MDU result transfers on any cycle where mdu_valid and
// mdu_ready are both 1; a WB request is taken on any cycle where wb_valid=1
// and wb_stall=0. Neither side may change its payload while waiting.
// WB owns the port in NORMAL. MDU results queue in a 2-entry FIFO and drain
// whenever WB is idle; an empty FIFO lets a fresh result bypass straight to
// the port. If the FIFO head loses to WB STARVE_LIMIT cycles in a row, one
// FORCE cycle stalls WB and commits the head.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [3:0]  wb_be,
  output logic        wb_stall,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  rd_addr,
  output logic        rs_busy,
  output logic        rt_busy,
  output logic        rd_busy,
  output logic        rf_wr_en,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic [3:0]  rf_be,
  output logic        state_dbg
);

  // Counter must hold STARVE_LIMIT for the one cycle before FORCE clears it.
  localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT - 1);

  arb_state_t state, state_nxt;

  logic       fifo_full;
  logic       fifo_empty;
  wr_req_t    fifo_head;
  wr_req_t    mdu_req;
  wr_req_t    win_req;
  logic       fifo_push;
  logic       fifo_pop;

  logic       mdu_xfer;
  logic       wb_win;
  logic       head_win;
  logic       byp_win;
  logic       mdu_commit;
  logic       any_win;
  logic       starve_hit;

  logic [CNT_W-1:0] starve_cnt;
  logic [31:0]      pend;
  logic [31:0]      pend_nxt;

  // ---------------- MDU result buffer ----------------
  assign mdu_req   = '{addr: mdu_addr, data: mdu_data, be: FULL_BE};
  assign mdu_ready = !fifo_full && !rst;
  assign mdu_xfer  = mdu_valid && mdu_ready;

  wr_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (mdu_req),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------- Port arbitration ----------------
  // wb_stall is asserted exactly in FORCE, so WB can only win in NORMAL.
  assign wb_win     = (state == NORMAL) && wb_valid;
  assign head_win   = !wb_win && !fifo_empty;
  assign byp_win    = !wb_win && fifo_empty && mdu_xfer;
  assign mdu_commit = head_win || byp_win;
  assign any_win    = wb_win || mdu_commit;

  assign fifo_pop   = head_win;
  assign fifo_push  = mdu_xfer && !byp_win;

  always_comb begin
    win_req = mdu_req;
    if (wb_win)        win_req = '{addr: wb_addr, data: wb_data, be: wb_be};
    else if (head_win) win_req = fifo_head;
  end

  // ---------------- Starvation counter ----------------
  assign starve_hit = wb_win && !fifo_empty && (starve_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if ((state == FORCE) || mdu_commit || fifo_empty) begin
      starve_cnt <= '0;
    end else if (wb_win) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // ---------------- Arbitration FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= NORMAL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      NORMAL:  if (starve_hit) state_nxt = FORCE;
      FORCE:   state_nxt = NORMAL;
      default: state_nxt = NORMAL;
    endcase
  end

  always_comb begin
    wb_stall  = (state == FORCE);
    state_dbg = (state == FORCE);
  end

  // ---------------- Pending scoreboard ----------------
  // Clear first so a same-cycle issue to the committing register wins.
  always_comb begin
    pend_nxt = pend;
    if (mdu_commit && (win_req.addr != 5'd0)) pend_nxt[win_req.addr] = 1'b0;
    if (issue_valid && (issue_addr != 5'd0))  pend_nxt[issue_addr]   = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= pend_nxt;
  end

  assign rs_busy = (rs_addr != 5'd0) && pend[rs_addr];
  assign rt_busy = (rt_addr != 5'd0) && pend[rt_addr];
  assign rd_busy = (rd_addr != 5'd0) && pend[rd_addr];

  // ---------------- Write-port registers ----------------
  // Address-0 commits are swallowed: no write strobe, payload regs hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr_en <= 1'b0;
      rf_addr  <= '0;
      rf_data  <= '0;
      rf_be    <= '0;
    end else begin
      rf_wr_en <= any_win && (win_req.addr != 5'd0);
      if (any_win && (win_req.addr != 5'd0)) begin
        rf_addr <= win_req.addr;
        rf_data <= win_req.data;
        rf_be   <= win_req.be;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  // ---------------- Clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wb_valid, mdu_valid, issue_valid;
  logic [4:0]  wb_addr, mdu_addr, issue_addr, rs_addr, rt_addr, rd_addr;
  logic [31:0] wb_data, mdu_data;
  logic [3:0]  wb_be;
  logic        wb_stall, mdu_ready, rs_busy, rt_busy, rd_busy;
  logic        rf_wr_en, state_dbg;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [3:0]  rf_be;

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_be(wb_be),
    .wb_stall(wb_stall),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .rd_busy(rd_busy),
    .rf_wr_en(rf_wr_en), .rf_addr(rf_addr), .rf_data(rf_data), .rf_be(rf_be),
    .state_dbg(state_dbg)
  );

  // ---------------- Vector table ----------------
  // Inputs held for one cycle; x_stall..x_rd are checked before the edge,
  // x_we (and the write payload) after it.
  typedef struct {
    logic        wb_v;  logic [4:0] wb_a;  logic [31:0] wb_d;  logic [3:0] wb_be;
    logic        mdu_v; logic [4:0] mdu_a; logic [31:0] mdu_d;
    logic        iss_v; logic [4:0] iss_a;
    logic [4:0]  rs_a, rt_a, rd_a;
    logic        x_stall, x_mrdy, x_rs, x_rt, x_rd, x_we;
    logic [4:0]  x_addr; logic [31:0] x_data; logic [3:0] x_be;
    logic        chk_hold;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  // Expected contents of the rf payload registers (they hold between writes).
  logic [4:0]  h_addr = 5'd0;
  logic [31:0] h_data = 32'd0;
  logic [3:0]  h_be   = 4'd0;

  function automatic vec_t nv();
    vec_t v;
    v = '{default: '0};
    v.x_mrdy   = 1'b1;
    v.chk_hold = 1'b1;
    return v;
  endfunction

  function automatic vec_t wbw(input vec_t vi, input logic [4:0] a, input logic [31:0] d,
                               input logic [3:0] be);
    vec_t v = vi;
    v.wb_v = 1'b1; v.wb_a = a; v.wb_d = d; v.wb_be = be;
    return v;
  endfunction

  function automatic vec_t mdw(input vec_t vi, input logic [4:0] a, input logic [31:0] d);
    vec_t v = vi;
    v.mdu_v = 1'b1; v.mdu_a = a; v.mdu_d = d;
    return v;
  endfunction

  function automatic vec_t xw(input vec_t vi, input logic [4:0] a, input logic [31:0] d,
                              input logic [3:0] be);
    vec_t v = vi;
    v.x_we = 1'b1; v.x_addr = a; v.x_data = d; v.x_be = be;
    return v;
  endfunction

  // ---------------- Scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; wb_be = 4'd0;
    mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0;
    issue_valid = 1'b0; issue_addr = 5'd0;
    rs_addr = 5'd0; rt_addr = 5'd0; rd_addr = 5'd0;
  endtask

  // ---------------- Driver ----------------
  task automatic run_vec(input vec_t v, input int i);
    @(negedge clk);
    wb_valid = v.wb_v; wb_addr = v.wb_a; wb_data = v.wb_d; wb_be = v.wb_be;
    mdu_valid = v.mdu_v; mdu_addr = v.mdu_a; mdu_data = v.mdu_d;
    issue_valid = v.iss_v; issue_addr = v.iss_a;
    rs_addr = v.rs_a; rt_addr = v.rt_a; rd_addr = v.rd_a;
    #1;
    check($sformatf("v%0d_stall", i),  32'(wb_stall),  32'(v.x_stall));
    check($sformatf("v%0d_state", i),  32'(state_dbg), 32'(v.x_stall));
    check($sformatf("v%0d_mready", i), 32'(mdu_ready), 32'(v.x_mrdy));
    check($sformatf("v%0d_rs_busy", i), 32'(rs_busy), 32'(v.x_rs));
    check($sformatf("v%0d_rt_busy", i), 32'(rt_busy), 32'(v.x_rt));
    check($sformatf("v%0d_rd_busy", i), 32'(rd_busy), 32'(v.x_rd));
    @(posedge clk);
    #1;
    check($sformatf("v%0d_wr_en", i), 32'(rf_wr_en), 32'(v.x_we));
    if (v.x_we) begin
      h_addr = v.x_addr; h_data = v.x_data; h_be = v.x_be;
    end
    if (v.chk_hold) begin
      check($sformatf("v%0d_rf_addr", i), 32'(rf_addr), 32'(h_addr));
      check($sformatf("v%0d_rf_data", i), rf_data, h_data);
      check($sformatf("v%0d_rf_be", i),   32'(rf_be),   32'(h_be));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // ---------------- Test ----------------
  initial begin
    vec_t v;
    drive_idle();

    // V0: plain WB write
    v = wbw(nv(), 5'd5, 32'h1234_5678, 4'hF); v.rs_a = 5'd5;
    tbl.push_back(xw(v, 5'd5, 32'h1234_5678, 4'hF));
    // V1: issue to 9, no same-cycle forwarding
    v = nv(); v.iss_v = 1'b1; v.iss_a = 5'd9; v.rs_a = 5'd9; tbl.push_back(v);
    // V2: MDU result 9 bypasses with WB idle
    v = mdw(nv(), 5'd9, 32'hDEAD_BEEF); v.rs_a = 5'd9; v.x_rs = 1'b1;
    tbl.push_back(xw(v, 5'd9, 32'hDEAD_BEEF, 4'hF));
    // V3: busy dropped in the output cycle
    v = nv(); v.rs_a = 5'd9; tbl.push_back(v);
    // V4, V5: issue 3 and 4
    v = nv(); v.iss_v = 1'b1; v.iss_a = 5'd3; tbl.push_back(v);
    v = nv(); v.iss_v = 1'b1; v.iss_a = 5'd4; v.rs_a = 5'd3; v.x_rs = 1'b1; tbl.push_back(v);
    // V6..V10: WB saturates, MDU 3 and 4 queue, 25 offered while full
    v = mdw(wbw(nv(), 5'd10, 32'hA0, 4'hF), 5'd3, 32'h33);
    v.rs_a = 5'd3; v.x_rs = 1'b1; v.rt_a = 5'd4; v.x_rt = 1'b1;
    tbl.push_back(xw(v, 5'd10, 32'hA0, 4'hF));
    v = mdw(wbw(nv(), 5'd11, 32'hA1, 4'hF), 5'd4, 32'h44);
    tbl.push_back(xw(v, 5'd11, 32'hA1, 4'hF));
    v = mdw(wbw(nv(), 5'd12, 32'hA2, 4'hF), 5'd25, 32'h55); v.x_mrdy = 1'b0;
    tbl.push_back(xw(v, 5'd12, 32'hA2, 4'hF));
    v = mdw(wbw(nv(), 5'd13, 32'hA3, 4'h3), 5'd25, 32'h55); v.x_mrdy = 1'b0;
    tbl.push_back(xw(v, 5'd13, 32'hA3, 4'h3));
    v = mdw(wbw(nv(), 5'd14, 32'hA4, 4'hF), 5'd25, 32'h55); v.x_mrdy = 1'b0;
    tbl.push_back(xw(v, 5'd14, 32'hA4, 4'hF));
    // V11: FORCE, head 3 commits, WB ignored
    v = mdw(wbw(nv(), 5'd15, 32'hA5, 4'hF), 5'd25, 32'h55);
    v.x_mrdy = 1'b0; v.x_stall = 1'b1; v.rs_a = 5'd3; v.x_rs = 1'b1;
    tbl.push_back(xw(v, 5'd3, 32'h33, 4'hF));
    // V12..V15: WB wins four more times over head 4
    v = wbw(nv(), 5'd15, 32'hA5, 4'hF); v.rs_a = 5'd3; v.rt_a = 5'd4; v.x_rt = 1'b1;
    tbl.push_back(xw(v, 5'd15, 32'hA5, 4'hF));
    tbl.push_back(xw(wbw(nv(), 5'd16, 32'hA6, 4'hF), 5'd16, 32'hA6, 4'hF));
    tbl.push_back(xw(wbw(nv(), 5'd17, 32'hA7, 4'hF), 5'd17, 32'hA7, 4'hF));
    tbl.push_back(xw(wbw(nv(), 5'd18, 32'hA8, 4'hF), 5'd18, 32'hA8, 4'hF));
    // V16: FORCE, head 4 commits
    v = wbw(nv(), 5'd19, 32'hA9, 4'hF); v.x_stall = 1'b1; v.rt_a = 5'd4; v.x_rt = 1'b1;
    tbl.push_back(xw(v, 5'd4, 32'h44, 4'hF));
    // V17: FIFO drained, rejected result 25 never appears
    v = nv(); v.rt_a = 5'd4; tbl.push_back(v);
    // V18..V20: address-0 writes from both sources are swallowed
    v = mdw(wbw(nv(), 5'd0, 32'hFF, 4'hF), 5'd0, 32'hEE);
    v.iss_v = 1'b1; v.chk_hold = 1'b0; tbl.push_back(v);
    v = nv(); v.chk_hold = 1'b0; tbl.push_back(v);
    v = nv(); v.chk_hold = 1'b0; tbl.push_back(v);
    // V21..V23: issue 7, then issue 7 again alongside its commit
    v = nv(); v.iss_v = 1'b1; v.iss_a = 5'd7; v.chk_hold = 1'b0; tbl.push_back(v);
    v = mdw(nv(), 5'd7, 32'h77); v.iss_v = 1'b1; v.iss_a = 5'd7; v.rd_a = 5'd7; v.x_rd = 1'b1;
    tbl.push_back(xw(v, 5'd7, 32'h77, 4'hF));
    v = nv(); v.rd_a = 5'd7; v.x_rd = 1'b1; tbl.push_back(v);
    // V24, V25: fill FIFO with 21 and 23, pend[3] set
    v = mdw(wbw(nv(), 5'd20, 32'hB0, 4'hF), 5'd21, 32'hC1); v.iss_v = 1'b1; v.iss_a = 5'd3;
    tbl.push_back(xw(v, 5'd20, 32'hB0, 4'hF));
    v = mdw(wbw(nv(), 5'd22, 32'hB2, 4'hF), 5'd23, 32'hC3);
    tbl.push_back(xw(v, 5'd22, 32'hB2, 4'hF));

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en",  32'(rf_wr_en),  32'd0);
    check("rst_addr",   32'(rf_addr),   32'd0);
    check("rst_data",   rf_data,        32'd0);
    check("rst_be",     32'(rf_be),     32'd0);
    check("rst_stall",  32'(wb_stall),  32'd0);
    check("rst_mready", 32'(mdu_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_mready", 32'(mdu_ready), 32'd1);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Mid-operation reset with a full FIFO and pend[3]
    @(negedge clk);
    drive_idle();
    rs_addr = 5'd3; rd_addr = 5'd7;
    #1;
    check("pre_rst_rs_busy", 32'(rs_busy),   32'd1);
    check("pre_rst_mready",  32'(mdu_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_wr_en",   32'(rf_wr_en),  32'd0);
    check("mid_rst_addr",    32'(rf_addr),   32'd0);
    check("mid_rst_data",    rf_data,        32'd0);
    check("mid_rst_be",      32'(rf_be),     32'd0);
    check("mid_rst_stall",   32'(wb_stall),  32'd0);
    check("mid_rst_mready",  32'(mdu_ready), 32'd0);
    check("mid_rst_rs_busy", 32'(rs_busy),   32'd0);
    check("mid_rst_rd_busy", 32'(rd_busy),   32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_mready", 32'(mdu_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst_wr_en%0d", k), 32'(rf_wr_en), 32'd0);
      check($sformatf("post_rst_addr%0d", k),  32'(rf_addr),  32'd0);
      check($sformatf("post_rst_rs%0d", k),    32'(rs_busy),  32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
